// File: rtl/imgproc.sv
// Bayer 2x2 binning to grayscale followed by an optional 3x3 Sobel edge magnitude.
// Produces one registered result per raw pixel at odd column and odd row. The result is replicated on R, G and B.
module imgproc #(
   parameter int IMG_WIDTH = 1280,
   parameter int DATA_W    = 12
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [DATA_W-1:0] iDATA,
   input  logic              iDVAL,
   input  logic [15:0]       iX_Cont,
   input  logic [15:0]       iY_Cont,
   input  logic              iSW,
   output logic [DATA_W-1:0] oRed,
   output logic [DATA_W-1:0] oGreen,
   output logic [DATA_W-1:0] oBlue,
   output logic              oDVAL
);

   localparam int GRAY_W = IMG_WIDTH / 2;
   localparam int RAW_AW = $clog2(IMG_WIDTH);
   localparam int G_AW   = $clog2(GRAY_W);
   localparam int SUM_W  = DATA_W + 2;
   localparam int K_W    = DATA_W + 4;
   localparam logic [15:0]    X_LIM = 16'(IMG_WIDTH);
   localparam logic [K_W-1:0] MAX_V = {{(K_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   logic [DATA_W-1:0] r_rawBuf [0:IMG_WIDTH-1];
   logic [DATA_W-1:0] r_lb1    [0:GRAY_W-1];
   logic [DATA_W-1:0] r_lb2    [0:GRAY_W-1];

   logic [DATA_W-1:0] r_p, r_q;
   logic [DATA_W-1:0] r_top [0:1];
   logic [DATA_W-1:0] r_mid [0:1];
   logic [DATA_W-1:0] r_bot [0:1];
   logic [DATA_W-1:0] r_res;
   logic              r_dval;

   logic              w_qual, w_gen, w_border;
   logic [RAW_AW-1:0] w_rawIdx;
   logic [G_AW-1:0]   w_gIdx;
   logic [14:0]       w_gx, w_gy;
   logic [DATA_W-1:0] w_old, w_gray, w_l1, w_l2, w_magSat, w_edge;
   logic [SUM_W-1:0]  w_sum;
   logic signed [K_W-1:0] w_gxv, w_gyv;
   logic [K_W-1:0]    w_ax, w_ay, w_mag;

   function automatic logic signed [K_W-1:0] ext(input logic [DATA_W-1:0] v);
      return signed'({{(K_W-DATA_W){1'b0}}, v});
   endfunction

   assign w_qual   = !iRST && iDVAL && (iX_Cont < X_LIM);
   assign w_gen    = w_qual && iX_Cont[0] && iY_Cont[0];
   assign w_rawIdx = iX_Cont[RAW_AW-1:0];
   assign w_gIdx   = iX_Cont[G_AW:1];
   assign w_gx     = iX_Cont[15:1];
   assign w_gy     = iY_Cont[15:1];
   assign w_border = (w_gx < 15'd2) || (w_gy < 15'd2);

   // The old entry is read combinationally before the write takes effect at the clock edge.
   assign w_old  = r_rawBuf[w_rawIdx];
   assign w_sum  = {2'b00, r_q} + {2'b00, w_old} + {2'b00, r_p} + {2'b00, iDATA};
   assign w_gray = w_sum[SUM_W-1:2];

   assign w_l1 = r_lb1[w_gIdx];
   assign w_l2 = r_lb2[w_gIdx];

   // The current column comes straight from the line buffers and the new gray sample. Index 0 is the left column.
   assign w_gxv = (ext(w_l2) + ext(w_l1) + ext(w_l1) + ext(w_gray))
                - (ext(r_top[0]) + ext(r_mid[0]) + ext(r_mid[0]) + ext(r_bot[0]));
   assign w_gyv = (ext(r_bot[0]) + ext(r_bot[1]) + ext(r_bot[1]) + ext(w_gray))
                - (ext(r_top[0]) + ext(r_top[1]) + ext(r_top[1]) + ext(w_l2));
   assign w_ax     = w_gxv[K_W-1] ? -w_gxv : w_gxv;
   assign w_ay     = w_gyv[K_W-1] ? -w_gyv : w_gyv;
   assign w_mag    = w_ax + w_ay;
   assign w_magSat = (w_mag > MAX_V) ? {DATA_W{1'b1}} : w_mag[DATA_W-1:0];
   assign w_edge   = w_border ? '0 : w_magSat;

   always_ff @(posedge iCLK) begin
      if (w_qual) begin
         r_rawBuf[w_rawIdx] <= iDATA;
      end
      if (w_gen) begin
         r_lb1[w_gIdx] <= w_gray;
         r_lb2[w_gIdx] <= w_l1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_p <= '0;
         r_q <= '0;
      end else if (w_qual) begin
         r_p <= iDATA;
         r_q <= w_old;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < 2; i++) begin
            r_top[i] <= '0;
            r_mid[i] <= '0;
            r_bot[i] <= '0;
         end
      end else if (w_gen) begin
         r_top[0] <= r_top[1];
         r_mid[0] <= r_mid[1];
         r_bot[0] <= r_bot[1];
         r_top[1] <= w_l2;
         r_mid[1] <= w_l1;
         r_bot[1] <= w_gray;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_res  <= '0;
         r_dval <= 1'b0;
      end else begin
         r_dval <= w_gen;
         if (w_gen) begin
            r_res <= iSW ? w_edge : w_gray;
         end
      end
   end

   assign oRed   = r_res;
   assign oGreen = r_res;
   assign oBlue  = r_res;
   assign oDVAL  = r_dval;

endmodule

// File: tb/tb_imgproc.sv
// Scoreboard bench for imgproc: stimulus pushes expected results, a negedge monitor pops and compares.
// Expectations come from hand values at key points and from a frame-level coordinate model elsewhere.
module tb_imgproc;

   localparam int W  = 1280;
   localparam int DW = 12;

   logic          iCLK = 1'b0;
   logic          iRST, iDVAL, iSW;
   logic [DW-1:0] iDATA;
   logic [15:0]   iX_Cont, iY_Cont;
   logic [DW-1:0] oRed, oGreen, oBlue;
   logic          oDVAL;

   typedef struct {int x; int y; int val;} exp_t;
   exp_t expQ[$];

   int   nVec = 0;
   int   nErr = 0;
   int   pulseCnt = 0;
   int   lastExp = 0;
   logic rstSampled = 1'b0;
   logic started = 1'b0;

   always #5 iCLK = ~iCLK;

   imgproc #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
      .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iSW(iSW),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL)
   );

   function automatic int rawVal(input int pat, input int x, input int y);
      if (pat == 0) return ((y % 64) << 6) | (x % 64);
      return (((y >> 2) & 1) == 1) ? 4095 : 0;
   endfunction

   function automatic int grayVal(input int pat, input int gx, input int gy);
      return (rawVal(pat, 2*gx, 2*gy) + rawVal(pat, 2*gx+1, 2*gy)
            + rawVal(pat, 2*gx, 2*gy+1) + rawVal(pat, 2*gx+1, 2*gy+1)) >> 2;
   endfunction

   function automatic int edgeVal(input int pat, input int gx, input int gy);
      int p [3][3];
      int sx, sy;
      if (gx < 2 || gy < 2) return 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[r][c] = grayVal(pat, gx - 2 + c, gy - 2 + r);
      sx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      sy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      if (sx < 0) sx = -sx;
      if (sy < 0) sy = -sy;
      return (sx + sy > 4095) ? 4095 : sx + sy;
   endfunction

   // Hand-derived values take precedence at the points where they are known.
   function automatic int expectFor(input int pat, input int x, input int y, input int sw);
      int gx, gy, v;
      gx = x >> 1;
      gy = y >> 1;
      v  = (sw != 0) ? edgeVal(pat, gx, gy) : grayVal(pat, gx, gy);
      if (pat == 0 && sw == 0 && x == 1 && y == 1) v = 32;
      if (pat == 0 && sw == 0 && x == 5 && y == 3) v = 164;
      if (sw != 0 && (gx < 2 || gy < 2)) v = 0;
      else if (pat == 0 && sw != 0 && x < 62 && y < 62) v = 1040;
      else if (pat == 1 && sw != 0) v = 4095;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp, input int x, input int y);
      nVec++;
      if (act != exp) begin
         nErr++;
         $display("[TB] FAIL %s at raw (%0d,%0d): got %0d, expected %0d", name, x, y, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic dval, input int x, input int y, input int data,
                                input int sw, input int expVal);
      @(posedge iCLK);
      #1;
      iDVAL   = dval;
      iX_Cont = 16'(x);
      iY_Cont = 16'(y);
      iDATA   = DW'(data);
      iSW     = (sw != 0);
      if (dval && x < W && (x % 2) == 1 && (y % 2) == 1)
         expQ.push_back('{x, y, expVal});
   endtask

   task automatic applyReset();
      @(posedge iCLK);
      #1;
      iRST = 1'b1; iDVAL = 1'b1; iX_Cont = 16'd1; iY_Cont = 16'd1; iDATA = 12'hABC; iSW = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;
      iRST = 1'b0; iDVAL = 1'b0;
   endtask

   task automatic flush();
      repeat (3) applyStimulus(1'b0, 0, 0, 0, 0, 0);
      @(negedge iCLK);
      #1;
      checkOutput("queue drained", expQ.size(), 0, -1, -1);
   endtask

   // swMode 2 picks iSW at random on every cycle, including gap cycles.
   task automatic runFrame(input int pat, input int rows, input int swMode, input bit gaps, input bit cadence);
      int sw, rowStart;
      for (int y = 0; y < rows; y++) begin
         rowStart = pulseCnt;
         for (int x = 0; x < W; x++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) begin
                  if ($urandom_range(0, 1) == 0)
                     applyStimulus(1'b0, 2*$urandom_range(0, W/2-1)+1, y | 1, $urandom_range(0, 4095),
                                   $urandom_range(0, 1), 0);
                  else
                     applyStimulus(1'b1, W + 2*$urandom_range(0, 40) + 1, y | 1, $urandom_range(0, 4095),
                                   $urandom_range(0, 1), 0);
               end
            end
            sw = (swMode == 2) ? $urandom_range(0, 1) : swMode;
            applyStimulus(1'b1, x, y, rawVal(pat, x, y), sw, expectFor(pat, x, y, sw));
         end
         if (cadence && y < 2) begin
            applyStimulus(1'b0, 0, 0, 0, 0, 0);
            @(negedge iCLK);
            #1;
            checkOutput("cadence pulses per row", pulseCnt - rowStart, (y % 2 == 1) ? W/2 : 0, -1, y);
         end
      end
   endtask

   always @(posedge iCLK) rstSampled = iRST;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge iCLK);
         if (rstSampled) begin
            started = 1'b1;
            lastExp = 0;
            checkOutput("reset oDVAL", int'(oDVAL), 0, -1, -1);
            checkOutput("reset oRed", int'(oRed), 0, -1, -1);
            checkOutput("reset oGreen", int'(oGreen), 0, -1, -1);
            checkOutput("reset oBlue", int'(oBlue), 0, -1, -1);
            continue;
         end
         if (!started) continue;
         if (oDVAL) begin
            pulseCnt++;
            if (expQ.size() == 0) begin
               checkOutput("unexpected oDVAL", 1, 0, -1, -1);
            end else begin
               e = expQ.pop_front();
               checkOutput("oRed", int'(oRed), e.val, e.x, e.y);
               checkOutput("oGreen", int'(oGreen), e.val, e.x, e.y);
               checkOutput("oBlue", int'(oBlue), e.val, e.x, e.y);
               lastExp = e.val;
            end
         end else begin
            checkOutput("hold oRed", int'(oRed), lastExp, -1, -1);
         end
      end
   end

   initial begin
      iRST = 1'b0; iDVAL = 1'b0; iSW = 1'b0; iDATA = '0; iX_Cont = '0; iY_Cont = '0;
      applyReset();
      $display("[TB] gray ramp, full rate");
      runFrame(0, 6, 0, 1'b0, 1'b1);
      flush();
      applyReset();
      $display("[TB] edge ramp");
      runFrame(0, 6, 1, 1'b0, 1'b0);
      flush();
      $display("[TB] partial frame then reset mid-frame");
      runFrame(0, 3, 1, 1'b0, 1'b0);
      applyReset();
      $display("[TB] gaps, out-of-range columns and random mode");
      runFrame(0, 6, 2, 1'b1, 1'b0);
      flush();
      applyReset();
      $display("[TB] saturation pattern");
      runFrame(1, 8, 1, 1'b0, 1'b0);
      flush();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
